cpu_bus_dma_router: RTL

CPU-side bus router with an integrated OAM DMA engine. It splits the 16-bit CPU bus into a downstream MMU region and an HRAM region at a parametrised boundary. It also owns the DMA source register and, on a write to it, copies `DMA_LEN` bytes from `{src_hi, 8'h00}` to `DMA_DST`. While that copy runs it holds the MMU port and locks the CPU out of everything except HRAM. It sits between the CPU core and the MMU/HRAM, replacing the plain combinational split.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/cpu_bus_dma_router_if.sv | 37 +++
 rtl/cpu_bus_dma_router_dma.sv | 87 ++++++++
 rtl/cpu_bus_dma_router.sv | 84 ++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and default constants for the CPU bus router and its OAM DMA engine.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } dma_state_e;

    localparam logic [15:0] HRAM_BASE_DEF = 16'hFF80;
    localparam logic [15:0] DMA_REG_DEF   = 16'hFF46;
    localparam logic [15:0] DMA_DST_DEF   = 16'hFE00;
    localparam int          DMA_LEN_DEF   = 160;
    localparam logic [7:0]  ECHO_HI_DEF   = 8'hE0;

    // Sources in the echo area are folded back onto the RAM they mirror.
    function automatic logic [7:0] echo_clamp(input logic [7:0] hi, input logic [7:0] echo_hi);
        return (hi >= echo_hi) ? hi - 8'h20 : hi;
    endfunction

endpackage

// File: rtl/cpu_bus_dma_router_if.sv
// CPU / MMU / HRAM bus bundle; the router uses the slave view, the environment the master view.
interface cpu_bus_dma_router_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int HRAM_AW = 7
);
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_wr;
    logic               cpu_rd;
    logic [ADDR_W-1:0]  mmu_addr;
    logic [DATA_W-1:0]  mmu_wdata;
    logic [DATA_W-1:0]  mmu_rdata;
    logic               mmu_cs;
    logic               mmu_wr;
    logic               mmu_rd;
    logic [HRAM_AW-1:0] hram_addr;
    logic [DATA_W-1:0]  hram_wdata;
    logic [DATA_W-1:0]  hram_rdata;
    logic               hram_cs;
    logic               hram_wr;
    logic               hram_rd;
    logic               dma_active;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd, mmu_rdata, hram_rdata,
        output cpu_rdata, mmu_addr, mmu_wdata, mmu_cs, mmu_wr, mmu_rd,
               hram_addr, hram_wdata, hram_cs, hram_wr, hram_rd, dma_active
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr, cpu_rd, mmu_rdata, hram_rdata,
        input  cpu_rdata, mmu_addr, mmu_wdata, mmu_cs, mmu_wr, mmu_rd,
               hram_addr, hram_wdata, hram_cs, hram_wr, hram_rd, dma_active
    );
endinterface

// File: rtl/cpu_bus_dma_router_dma.sv
// OAM DMA engine: source register, copy FSM, byte index and staging byte.
module oam_dma_engine
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 8,
    parameter logic [ADDR_W-1:0] DMA_DST = DMA_DST_DEF,
    parameter int                DMA_LEN = DMA_LEN_DEF,
    parameter logic [7:0]        ECHO_HI = ECHO_HI_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mmu_rdata_i,
    output logic [7:0]        src_hi_o,
    output logic              active_o,
    output logic [ADDR_W-1:0] mmu_addr_o,
    output logic [DATA_W-1:0] mmu_wdata_o,
    output logic              mmu_rd_o,
    output logic              mmu_wr_o
);
    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [7:0]        src_hi_q, src_hi_d;
    logic [7:0]        eff_hi;

    assign eff_hi   = echo_clamp(src_hi_q, ECHO_HI);
    assign src_hi_o = src_hi_q;
    assign active_o = (state_q != ST_IDLE);

    // State, index, staging byte and source register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            byte_q   <= '0;
            src_hi_q <= 8'hFF;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            src_hi_q <= src_hi_d;
        end
    end

    // Next state and MMU drive; a register write restarts from any state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        src_hi_d    = start_i ? 8'(wdata_i) : src_hi_q;
        mmu_addr_o  = '0;
        mmu_wdata_o = '0;
        mmu_rd_o    = 1'b0;
        mmu_wr_o    = 1'b0;
        case (state_q)
            ST_START: begin
                idx_d   = '0;
                state_d = ST_RD;
            end
            ST_RD: begin
                mmu_addr_o = ADDR_W'({eff_hi, idx_q});
                mmu_rd_o   = 1'b1;
                byte_d     = mmu_rdata_i;
                state_d    = ST_WR;
            end
            ST_WR: begin
                mmu_addr_o  = DMA_DST + ADDR_W'(idx_q);
                mmu_wdata_o = byte_q;
                mmu_wr_o    = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_RD;
                end
            end
            default: ;
        endcase
        if (start_i) state_d = ST_START;
    end

endmodule

// File: rtl/cpu_bus_dma_router.sv
// CPU bus router: MMU/HRAM decode, DMA lockout gating and read-data mux.
module cpu_bus_dma_router
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] HRAM_BASE = HRAM_BASE_DEF,
    parameter int                HRAM_AW   = 7,
    parameter logic [ADDR_W-1:0] DMA_REG   = DMA_REG_DEF,
    parameter logic [ADDR_W-1:0] DMA_DST   = DMA_DST_DEF,
    parameter int                DMA_LEN   = DMA_LEN_DEF,
    parameter logic [7:0]        ECHO_HI   = ECHO_HI_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_bus_dma_router_if.slave  bus
);
    logic              hram_sel, reg_hit, wr, rd, dma_start, active;
    logic [7:0]        src_hi;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_rd, eng_wr;

    // Write wins when the CPU raises both strobes.
    assign wr        = bus.cpu_wr;
    assign rd        = bus.cpu_rd & ~bus.cpu_wr;
    assign hram_sel  = (bus.cpu_addr >= HRAM_BASE);
    assign reg_hit   = (bus.cpu_addr == DMA_REG);
    assign dma_start = ~hram_sel & reg_hit & wr;

    oam_dma_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DMA_DST(DMA_DST),
        .DMA_LEN(DMA_LEN),
        .ECHO_HI(ECHO_HI)
    ) u_dma (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (dma_start),
        .wdata_i    (bus.cpu_wdata),
        .mmu_rdata_i(bus.mmu_rdata),
        .src_hi_o   (src_hi),
        .active_o   (active),
        .mmu_addr_o (eng_addr),
        .mmu_wdata_o(eng_wdata),
        .mmu_rd_o   (eng_rd),
        .mmu_wr_o   (eng_wr)
    );

    assign bus.dma_active = active;

    // HRAM stays CPU-driven regardless of DMA.
    assign bus.hram_addr  = HRAM_AW'(bus.cpu_addr - HRAM_BASE);
    assign bus.hram_wdata = (hram_sel & wr) ? bus.cpu_wdata : '0;
    assign bus.hram_wr    = hram_sel & wr;
    assign bus.hram_rd    = hram_sel & rd;
    assign bus.hram_cs    = hram_sel & (wr | rd);

    // MMU port: CPU when idle, engine while a transfer owns it (CPU dropped).
    always_comb begin
        bus.mmu_addr  = bus.cpu_addr;
        bus.mmu_wdata = (~hram_sel & wr) ? bus.cpu_wdata : '0;
        bus.mmu_wr    = ~hram_sel & wr;
        bus.mmu_rd    = ~hram_sel & rd;
        bus.mmu_cs    = ~hram_sel & (wr | rd);
        if (active) begin
            bus.mmu_addr  = eng_addr;
            bus.mmu_wdata = eng_wdata;
            bus.mmu_wr    = eng_wr;
            bus.mmu_rd    = eng_rd;
            bus.mmu_cs    = eng_wr | eng_rd;
        end
    end

    // Read data: HRAM, then the source register, then lockout filler, then MMU.
    always_comb begin
        if (hram_sel)     bus.cpu_rdata = bus.hram_rdata;
        else if (reg_hit) bus.cpu_rdata = DATA_W'(src_hi);
        else if (active)  bus.cpu_rdata = '1;
        else              bus.cpu_rdata = bus.mmu_rdata;
    end

endmodule
